// File: rtl/dff_pipe.sv
// Elastic WIDTH x STAGES register pipeline with valid/ready handshakes, flush and Q/QN outputs.
// Define DFF_PIPE_OCC_EN to add the registered occupancy output OCC.
module dff_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(STAGES+1)-1:0] OCC
`endif
);

  logic [STAGES-1:0]            valid_q, valid_d, adv;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic                         slot;
  logic                         accept;

  // Walk from the output side; slot says whether the stage ahead frees up this cycle,
  // which lets free slots ripple back and collapse bubbles.
  always_comb begin
    adv  = '0;
    slot = OUT_READY;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      adv[i] = valid_q[i] & slot;
      slot   = slot | ~valid_q[i];
    end
  end

  assign IN_READY = ~FLUSH & (~valid_q[0] | adv[0]);
  assign accept   = IN_VALID & IN_READY;

  always_comb begin
    valid_d    = '0;
    valid_d[0] = accept | (valid_q[0] & ~adv[0]);
    for (int i = 1; i < int'(STAGES); i++) begin
      valid_d[i] = adv[i-1] | (valid_q[i] & ~adv[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      data_q  <= '0;
    end else if (FLUSH) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        data_q[0] <= D;
      end
      for (int i = 1; i < int'(STAGES); i++) begin
        if (adv[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign OUT_VALID = valid_q[STAGES-1];
  assign Q         = data_q[STAGES-1];
  assign QN        = ~data_q[STAGES-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int unsigned OccW = $clog2(STAGES + 1);

  logic [OccW-1:0] occ_q;

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OccW'(accept) - OccW'(adv[STAGES-1]);
    end
  end

  assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: directed scenarios plus random traffic against a word-position queue model.
module tb_dff_pipe;
  localparam int W = 8;
  localparam int S = 3;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] qn;
`ifdef DFF_PIPE_OCC_EN
  logic [$clog2(S+1)-1:0] occ;
`endif

  dff_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .CLK      (clk),
    .RST      (rst),
    .FLUSH    (flush),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .D        (d),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .Q        (q),
    .QN       (qn)
`ifdef DFF_PIPE_OCC_EN
    ,
    .OCC      (occ)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: every word in flight with the stage index it currently occupies, head first.
  int           pos_q[$];
  logic [W-1:0] dat_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] dv, input logic ordy,
                       input logic fl, input logic rs, input bit check_en);
    logic         exp_rdy, exp_ov, emit, acc;
    logic [W-1:0] exp_qn;
    int           lim;
    @(negedge clk);
    in_valid  = iv;
    d         = dv;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    exp_rdy = !fl && (pos_q.size() < S || ordy);
    exp_ov  = pos_q.size() > 0 && pos_q[0] == S - 1;
    if (check_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        exp_qn = ~dat_q[0];
        chk("q", 32'(q), 32'(dat_q[0]));
        chk("qn", 32'(qn), 32'(exp_qn));
      end
`ifdef DFF_PIPE_OCC_EN
      chk("occ", 32'(occ), 32'(pos_q.size()));
`endif
    end
    acc  = iv && exp_rdy && !rs;
    emit = exp_ov && ordy;
    last_acc = acc;
    @(posedge clk);
    if (rs) begin
      pos_q.delete();
      dat_q.delete();
    end else begin
      if (emit) begin
        void'(pos_q.pop_front());
        void'(dat_q.pop_front());
      end
      lim = S;
      for (int j = 0; j < pos_q.size(); j++) begin
        pos_q[j] = (pos_q[j] + 1 < lim - 1) ? pos_q[j] + 1 : lim - 1;
        lim      = pos_q[j];
      end
      if (fl) begin
        pos_q.delete();
        dat_q.delete();
      end else if (acc) begin
        pos_q.push_back(0);
        dat_q.push_back(dv);
      end
    end
  endtask

  logic         pend_v;
  logic [W-1:0] pend_d;
  logic         r_ordy, r_fl, r_rs;

  initial begin
    in_valid = 0; d = '0; out_ready = 0; flush = 0; rst = 1;
    // Reset with a word offered; nothing may be accepted.
    cycle(1, 8'hA5, 0, 0, 1, 0);
    cycle(1, 8'hA5, 0, 0, 1, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_qn", 32'(qn), 32'hFF);
    cycle(0, 8'h00, 1, 0, 0, 1);
    cycle(0, 8'h00, 1, 0, 0, 1);

    // Streaming.
    for (int k = 1; k <= 4; k++) cycle(1, W'(k), 1, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1, 0, 0, 1);

    // Backpressure, then drain in order.
    cycle(1, 8'd10, 0, 0, 0, 1);
    cycle(1, 8'd11, 0, 0, 0, 1);
    cycle(1, 8'd12, 0, 0, 0, 1);
    cycle(1, 8'd13, 0, 0, 0, 1);
    cycle(1, 8'd13, 0, 0, 0, 1);
    cycle(1, 8'd13, 1, 0, 0, 1);
    for (int k = 0; k < 5; k++) cycle(0, 8'h00, 1, 0, 0, 1);

    // Bubble collapse behind a stalled word.
    cycle(1, 8'd20, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(1, 8'd21, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);

    // Fill, then flush with a word offered; 8'h55 must never surface.
    cycle(1, 8'd22, 0, 0, 0, 1);
    cycle(1, 8'h55, 0, 1, 0, 1);
    for (int k = 0; k < 4; k++) cycle(0, 8'h00, 1, 0, 0, 1);

    // Full pipe with simultaneous emit and accept, then reset mid-stream.
    for (int k = 0; k < 3; k++) cycle(1, W'(8'h30 + k), 0, 0, 0, 1);
    cycle(1, 8'h33, 1, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0, 1);
    cycle(1, 8'h34, 1, 0, 1, 1);
    cycle(0, 8'h00, 1, 0, 0, 1);
    chk("midrst_q", 32'(q), 32'h00);
    cycle(0, 8'h00, 1, 0, 0, 1);

    // Random traffic; an offered word is held until accepted.
    pend_v = 0;
    pend_d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_v && $urandom_range(3) != 0) begin
        pend_v = 1;
        pend_d = W'($urandom);
      end
      r_ordy = 1'($urandom_range(1));
      r_fl   = ($urandom_range(40) == 0);
      r_rs   = ($urandom_range(150) == 0);
      cycle(pend_v, pend_d, r_ordy, r_fl, r_rs, 1);
      if (last_acc || r_rs) pend_v = 0;
    end
    for (int k = 0; k < 5; k++) cycle(0, 8'h00, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
